// File: rtl/dct_block_loader.sv
// Ping-pong 8x8 block assembler feeding the 2-D DCT: raster pixels in, one flat
// N*64-bit block word out, with optional level shift to signed samples.
module dct_block_loader #(
  parameter int N           = 16,
  parameter int PIX_W       = 8,
  parameter int LEVEL_SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_first,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [N*64-1:0]  blk_data,
  output logic             sync_err
);

  localparam logic [N-1:0] OFFSET = {{(N-1){1'b0}}, 1'b1} << (PIX_W-1);

  // bank[b][idx] holds sample idx = 8*row + col, so bank[b] is already the
  // row-major flat layout the DCT expects.
  logic [1:0][63:0][N-1:0] bank;
  logic [1:0]              full;
  logic                    wr_bank;
  logic                    rd_bank;
  logic [5:0]              wr_cnt;
  logic                    sync_err_q;

  logic                    pix_acc;
  logic                    blk_acc;
  logic                    resync;
  logic [5:0]              wr_idx;
  logic [N-1:0]            pix_ext;
  logic [N-1:0]            sample;

  // NOTE: every variable written in always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    pix_ext = {{(N-PIX_W){1'b0}}, pix_data};
    sample  = pix_ext;
    if (LEVEL_SHIFT != 0) sample = pix_ext - OFFSET;
  end

  // Ready depends only on registered occupancy, never on blk_ready.
  assign pix_ready = !full[wr_bank];
  assign blk_valid = full[rd_bank];
  assign blk_data  = bank[rd_bank];
  assign sync_err  = sync_err_q;

  assign pix_acc = pix_valid && pix_ready;
  assign blk_acc = blk_valid && blk_ready;
  assign resync  = pix_acc && pix_first && (wr_cnt != 6'd0);
  assign wr_idx  = resync ? 6'd0 : wr_cnt;

  // NOTE: the sample store is reset so blk_data reads 0 after reset; this costs a reset net on every bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
    end else if (pix_acc) begin
      bank[wr_bank][wr_idx] <= sample;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full       <= 2'b00;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= 6'd0;
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= resync;
      // A completing bank is never the bank being consumed, so both updates can land together.
      if (blk_acc) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= !rd_bank;
      end
      if (pix_acc) begin
        if (resync) begin
          wr_cnt <= 6'd1;
        end else if (wr_cnt == 6'd63) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
          wr_cnt        <= 6'd0;
        end else begin
          wr_cnt <= wr_cnt + 6'd1;
        end
      end
    end
  end

endmodule
